// File: rtl/alpha_block_v3.sv
// -----------------------------------------------------------------------------
// alpha_block_v3
// Per-channel HDR gain-selection controller with hysteresis and a release
// timeout. Each channel runs an ATTACK / RELEASE / QUIET state machine on
// valid-qualified samples; alpha (1 = attack / high-signal gain) and a
// one-cycle alpha_changed pulse are registered outputs.
//
// Optional feature macro: ALPHA_V3_LINK_EN
//   defined   : link_mode=1 drives every alpha bit with the OR of all channels
//   undefined : link_mode is ignored, channels are always independent
//
// Ports
//   clk               in   single clock
//   reset             in   synchronous, active-high reset
//   sample_valid      in   qualifies hdr_current_value for all channels
//   hdr_current_value in   NUM_CH signed samples, channel i at [i*DATA_W +: DATA_W]
//   threshold_high    in   unsigned attack threshold (strict >)
//   threshold_low     in   unsigned release threshold (strict <)
//   timeout_mask      in   selects counter MSBs that end the release timeout
//   link_mode         in   share one alpha across channels (with macro only)
//   alpha             out  registered gain select per channel
//   alpha_changed     out  one-cycle pulse when a visible alpha bit changes
// -----------------------------------------------------------------------------
module alpha_block_v3 #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned DATA_W = 9,
    parameter int unsigned TMO_W  = 18,
    parameter int unsigned MASK_W = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sample_valid,
    input  logic [NUM_CH*DATA_W-1:0] hdr_current_value,
    input  logic [DATA_W-1:0]        threshold_high,
    input  logic [DATA_W-1:0]        threshold_low,
    input  logic [MASK_W-1:0]        timeout_mask,
    input  logic                     link_mode,
    output logic [NUM_CH-1:0]        alpha,
    output logic [NUM_CH-1:0]        alpha_changed
);

    typedef enum logic [1:0] {
        ST_ATTACK  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_QUIET   = 2'd2
    } state_t;

    state_t            r_state   [NUM_CH];
    state_t            w_state_n [NUM_CH];
    logic [TMO_W-1:0]  r_cnt     [NUM_CH];
    logic [TMO_W-1:0]  w_cnt_n   [NUM_CH];
    logic [TMO_W-1:0]  w_cnt_inc [NUM_CH];
    logic [DATA_W-1:0] w_sample  [NUM_CH];
    logic [DATA_W-1:0] w_mag     [NUM_CH];
    logic [NUM_CH-1:0] w_above;
    logic [NUM_CH-1:0] w_below;
    logic [NUM_CH-1:0] w_alpha_int;
    logic [NUM_CH-1:0] w_alpha_nxt;
    logic [NUM_CH-1:0] r_alpha;
    logic [NUM_CH-1:0] r_alpha_changed;

    // Timeout reached when any selected counter MSB is set.
    function automatic logic f_expired(input logic [TMO_W-1:0]  c,
                                       input logic [MASK_W-1:0] m);
        return |(c[TMO_W-1 -: MASK_W] & m);
    endfunction

    // Magnitude and threshold classification; above wins over below.
    // Two's-complement negate: the most negative value maps to 2^(DATA_W-1).
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_sample[i] = hdr_current_value[i*DATA_W +: DATA_W];
            w_mag[i]    = w_sample[i][DATA_W-1] ? DATA_W'((~w_sample[i]) + DATA_W'(1))
                                                : w_sample[i];
            w_above[i]  = (w_mag[i] > threshold_high);
            w_below[i]  = !w_above[i] && (w_mag[i] < threshold_low);
        end
    end

    // State and counter register.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (reset) begin
                r_state[i] <= ST_ATTACK;
                r_cnt[i]   <= '0;
            end else begin
                r_state[i] <= w_state_n[i];
                r_cnt[i]   <= w_cnt_n[i];
            end
        end
    end

    // Next-state and counter logic per channel.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_state_n[i] = r_state[i];
            w_cnt_n[i]   = r_cnt[i];
            w_cnt_inc[i] = r_cnt[i] + TMO_W'(1);
            if (sample_valid) begin
                case (r_state[i])
                    ST_ATTACK: begin
                        if (w_below[i]) begin
                            w_cnt_n[i]   = TMO_W'(1);
                            w_state_n[i] = f_expired(TMO_W'(1), timeout_mask) ? ST_QUIET
                                                                                : ST_RELEASE;
                        end
                    end
                    ST_RELEASE: begin
                        if (w_above[i]) begin
                            w_cnt_n[i]   = '0;
                            w_state_n[i] = ST_ATTACK;
                        end else if (w_below[i]) begin
                            // A mask change may already have expired the held
                            // count; stop there rather than step past it.
                            if (f_expired(r_cnt[i], timeout_mask)) begin
                                w_state_n[i] = ST_QUIET;
                            end else begin
                                w_cnt_n[i] = w_cnt_inc[i];
                                if (f_expired(w_cnt_inc[i], timeout_mask)) begin
                                    w_state_n[i] = ST_QUIET;
                                end
                            end
                        end
                    end
                    ST_QUIET: begin
                        if (w_above[i]) begin
                            w_cnt_n[i]   = '0;
                            w_state_n[i] = ST_ATTACK;
                        end
                    end
                    default: begin
                        w_cnt_n[i]   = '0;
                        w_state_n[i] = ST_ATTACK;
                    end
                endcase
            end
        end
    end

    // Output decode from next state, optionally OR-combined across channels.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_alpha_int[i] = (w_state_n[i] != ST_QUIET);
        end
`ifdef ALPHA_V3_LINK_EN
        w_alpha_nxt = link_mode ? {NUM_CH{|w_alpha_int}} : w_alpha_int;
`else
        w_alpha_nxt = w_alpha_int;
`endif
    end

`ifndef ALPHA_V3_LINK_EN
    logic w_unused_link;
    assign w_unused_link = link_mode;
`endif

    // Output register; the change pulse compares against the visible value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_alpha         <= '1;
            r_alpha_changed <= '0;
        end else begin
            r_alpha         <= w_alpha_nxt;
            r_alpha_changed <= w_alpha_nxt ^ r_alpha;
        end
    end

    assign alpha         = r_alpha;
    assign alpha_changed = r_alpha_changed;

endmodule
